// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath controller and seq_alu.
// The controller side uses the master modport and the ALU uses the slave modport.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       sl;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             ovf;
  logic             div0;

  modport master (
    output start, sl, ain, bin,
    input  busy, done, alu_out, zero, ovf, div0
  );

  modport slave (
    input  start, sl, ain, bin,
    output busy, done, alu_out, zero, ovf, div0
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/busy/done handshake.
// Single-cycle ops: add, sub, and, or, xor and slt. Iterative ops: mul (shift-add)
// and divu (restoring), each taking one bit per cycle. All outputs are registered.
// The result and its flags change only on a done edge or on reset.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ITER} state_t;

  state_t           r_state,  w_state_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic             r_is_div, w_is_div_nxt;
  logic [WIDTH-1:0] r_a,      w_a_nxt;     // multiplier (mul) / dividend->quotient (divu)
  logic [WIDTH-1:0] r_b,      w_b_nxt;     // multiplicand (mul) / divisor (divu)
  logic [WIDTH-1:0] r_acc,    w_acc_nxt;   // partial product (mul) / remainder (divu)
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic [WIDTH-1:0] r_alu_out, w_alu_out_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic             r_div0,   w_div0_nxt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_fast_ovf;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_iter_res;

  // Single-cycle result and overflow, computed directly from the request operands.
  always_comb begin
    w_sum      = bus.ain + bus.bin;
    w_diff     = bus.ain - bus.bin;
    w_slt      = $signed(bus.ain) < $signed(bus.bin);
    w_fast_res = '0;
    w_fast_ovf = 1'b0;
    case (bus.sl)
      3'b000: begin
        w_fast_res = w_sum;
        w_fast_ovf = (bus.ain[WIDTH-1] == bus.bin[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.ain[WIDTH-1]);
      end
      3'b001: begin
        w_fast_res = w_diff;
        w_fast_ovf = (bus.ain[WIDTH-1] != bus.bin[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != bus.ain[WIDTH-1]);
      end
      3'b010:  w_fast_res = bus.ain & bus.bin;
      3'b011:  w_fast_res = bus.ain | bus.bin;
      3'b100:  w_fast_res = bus.ain ^ bus.bin;
      3'b101:  w_fast_res = WIDTH'(w_slt);
      default: w_fast_res = '0;
    endcase
  end

  // One iteration step of the shift-add multiplier and the restoring divider.
  // The divider compares with one extra bit so that the shifted remainder never wraps.
  // With a zero divisor every trial succeeds, so the quotient becomes all ones.
  always_comb begin
    w_mul_acc  = r_a[0] ? (r_acc + r_b) : r_acc;
    w_shift    = {r_acc, r_a[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_b});
    w_div_rem  = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
    w_quo      = {r_a[WIDTH-2:0], w_ge};
    w_iter_res = r_is_div ? w_quo : w_mul_acc;
  end

  // Next-state and next-output logic; every register holds its value unless updated.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_is_div_nxt  = r_is_div;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_acc_nxt     = r_acc;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_alu_out_nxt = r_alu_out;
    w_zero_nxt    = r_zero;
    w_ovf_nxt     = r_ovf;
    w_div0_nxt    = r_div0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.sl[2:1] == 2'b11) begin
            w_is_div_nxt = bus.sl[0];
            w_a_nxt      = bus.ain;
            w_b_nxt      = bus.bin;
            w_acc_nxt    = '0;
            w_cnt_nxt    = CW'(WIDTH);
            w_busy_nxt   = 1'b1;
            w_state_nxt  = ITER;
          end else begin
            w_alu_out_nxt = w_fast_res;
            w_zero_nxt    = (w_fast_res == '0);
            w_ovf_nxt     = w_fast_ovf;
            w_div0_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
          end
        end
      end
      ITER: begin
        w_a_nxt   = r_is_div ? w_quo : (r_a >> 1);
        w_b_nxt   = r_is_div ? r_b : (r_b << 1);
        w_acc_nxt = r_is_div ? w_div_rem : w_mul_acc;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_alu_out_nxt = w_iter_res;
          w_zero_nxt    = (w_iter_res == '0);
          w_ovf_nxt     = 1'b0;
          w_div0_nxt    = r_is_div && (r_b == '0);
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers; a synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_alu_out <= '0;
      r_zero    <= 1'b1;
      r_ovf     <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_is_div  <= w_is_div_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_acc     <= w_acc_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_alu_out <= w_alu_out_nxt;
      r_zero    <= w_zero_nxt;
      r_ovf     <= w_ovf_nxt;
      r_div0    <= w_div0_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.alu_out = r_alu_out;
  assign bus.zero    = r_zero;
  assign bus.ovf     = r_ovf;
  assign bus.div0    = r_div0;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8, driven by directed and random operations.
// Expected values come from a plain arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8  ();

  seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bz, output logic [63:0] r,
                        output logic z, output logic o, output logic dz);
    if (w == 32) begin
      d = bus32.done; bz = bus32.busy; r = 64'(bus32.alu_out);
      z = bus32.zero; o = bus32.ovf;  dz = bus32.div0;
    end else begin
      d = bus8.done;  bz = bus8.busy;  r = 64'(bus8.alu_out);
      z = bus8.zero;  o = bus8.ovf;   dz = bus8.div0;
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      bus32.start = s; bus32.sl = op; bus32.ain = a[31:0]; bus32.bin = b[31:0];
    end else begin
      bus8.start = s;  bus8.sl = op;  bus8.ain = a[7:0];   bus8.bin = b[7:0];
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  task automatic model(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic ov, output logic dz);
    logic [63:0] mask, ua, ub;
    longint sa, sb, s, maxv, minv;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -maxv - 1;
    ov = 1'b0;
    dz = 1'b0;
    r  = '0;
    case (op)
      3'd0: begin r = (ua + ub) & mask; s = sa + sb; ov = (s > maxv) || (s < minv); end
      3'd1: begin r = (ua - ub) & mask; s = sa - sb; ov = (s > maxv) || (s < minv); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd6: r = (ua * ub) & mask;
      default: begin
        if (ub == 0) begin r = mask; dz = 1'b1; end
        else r = ua / ub;
      end
    endcase
  endtask

  // Issues one operation and checks latency, busy window, result hold, and the final outputs.
  // If now=1, the request is driven in the current cycle (used for back-to-back issue in a done cycle).
  // If hammer=1, start stays high with junk operands while the operation is in progress.
  // The task returns at the negedge of the done cycle with start driven low.
  task automatic run_op(input string tag, input int w, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b, input bit now, input bit hammer);
    logic [63:0] er, prev, r;
    logic eo, ed, d, bz, z, o, dz;
    int done_cyc, busy_cnt, lat;
    bit held;
    done_cyc = -1;
    busy_cnt = 0;
    held = 1'b1;
    model(w, op, a, b, er, eo, ed);
    if (!now) @(negedge clk);
    sample(w, d, bz, prev, z, o, dz);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    for (int c = 1; c <= w + 4; c++) begin
      @(negedge clk);
      sample(w, d, bz, r, z, o, dz);
      if (d) begin
        done_cyc = c;
        break;
      end
      busy_cnt += int'(bz);
      if (r !== prev) held = 1'b0;
      if (hammer) drive(w, 1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
      else        drive(w, 1'b0, op, a, b);
    end
    drive(w, 1'b0, op, a, b);
    lat = (op[2:1] == 2'b11) ? w + 1 : 1;
    chk({tag, ".latency"}, 64'(done_cyc), 64'(lat));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    chk({tag, ".held"}, 64'(held), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(bz), 64'd0);
    chk({tag, ".alu_out"}, r, er);
    chk({tag, ".zero"}, 64'(z), 64'(er == 0));
    chk({tag, ".ovf"}, 64'(o), 64'(eo));
    chk({tag, ".div0"}, 64'(dz), 64'(ed));
  endtask

  initial begin
    logic d, bz, z, o, dz;
    logic [63:0] r, a, b, mask;
    logic [2:0] op;
    int w, nd;

    drive(32, 1'b0, 3'd0, 0, 0);
    drive(8, 1'b0, 3'd0, 0, 0);

    // Reset held two cycles with start asserted
    rst = 1'b1;
    drive(32, 1'b1, 3'd0, 64'd1, 64'd1);
    drive(8, 1'b1, 3'd0, 64'd1, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 8;
      sample(w, d, bz, r, z, o, dz);
      chk($sformatf("reset%0d.busy", w), 64'(bz), 64'd0);
      chk($sformatf("reset%0d.done", w), 64'(d), 64'd0);
      chk($sformatf("reset%0d.alu_out", w), r, 64'd0);
      chk($sformatf("reset%0d.zero", w), 64'(z), 64'd1);
      chk($sformatf("reset%0d.ovf_div0", w), {62'd0, o, dz}, 64'd0);
    end
    drive(32, 1'b0, 3'd0, 0, 0);
    drive(8, 1'b0, 3'd0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    sample(32, d, bz, r, z, o, dz);
    chk("reset.start_ignored", {62'd0, d, bz}, 64'd0);

    // Directed cases at both widths
    run_op("add32_ovf", 32, 3'd0, 64'h7FFFFFFF, 64'd1, 0, 0);
    run_op("sub32_zero", 32, 3'd1, 64'd5, 64'd5, 0, 0);
    run_op("slt32", 32, 3'd5, 64'hFFFFFFFF, 64'd1, 0, 0);
    run_op("xor32", 32, 3'd4, 64'hF0F0F0F0, 64'hFFFF0000, 0, 0);
    run_op("mul32", 32, 3'd6, 64'h10000, 64'h10001, 0, 0);
    run_op("divu32", 32, 3'd7, 64'd100, 64'd7, 0, 0);
    run_op("divu32_by0", 32, 3'd7, 64'd5, 64'd0, 0, 0);
    run_op("add8_ovf", 8, 3'd0, 64'h7F, 64'd1, 0, 0);
    run_op("sub8_zero", 8, 3'd1, 64'd5, 64'd5, 0, 0);
    run_op("slt8", 8, 3'd5, 64'hFF, 64'd1, 0, 0);
    run_op("xor8", 8, 3'd4, 64'hF0, 64'h3C, 0, 0);
    run_op("mul8", 8, 3'd6, 64'h10, 64'h11, 0, 0);
    run_op("divu8", 8, 3'd7, 64'd100, 64'd7, 0, 0);
    run_op("divu8_by0", 8, 3'd7, 64'd5, 64'd0, 0, 0);

    // Start held high during a multiply: exactly one done, operands not re-sampled
    run_op("mul32_hammer", 32, 3'd6, 64'h1234, 64'h5678, 0, 1);
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sample(32, d, bz, r, z, o, dz);
      nd += int'(d);
    end
    chk("hammer.extra_done", 64'(nd), 64'd0);

    // Back-to-back issue: an add launched in the done cycle of a multiply
    run_op("mul32_b2b", 32, 3'd6, 64'd3, 64'd9, 0, 0);
    run_op("add32_b2b", 32, 3'd0, 64'd40, 64'd2, 1, 0);

    // Reset during a divide: no done, then an add is accepted in the first cycle after reset
    @(negedge clk);
    drive(32, 1'b1, 3'd7, 64'd1000, 64'd3);
    @(posedge clk);
    @(negedge clk);
    drive(32, 1'b0, 3'd7, 64'd1000, 64'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(32, d, bz, r, z, o, dz);
    chk("rst_mid.busy_done", {62'd0, d, bz}, 64'd0);
    chk("rst_mid.alu_out", r, 64'd0);
    run_op("rst_mid.add", 32, 3'd0, 64'd2, 64'd3, 1, 0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sample(32, d, bz, r, z, o, dz);
      nd += int'(d) + int'(bz);
    end
    chk("rst_mid.no_late_done", 64'(nd), 64'd0);

    // Random operations on both widths
    for (int i = 0; i < 30; i++) begin
      w = (i % 2 == 0) ? 32 : 8;
      mask = (64'd1 << w) - 64'd1;
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom} & mask;
      b = {$urandom, $urandom} & mask;
      if (i % 5 == 0) a = mask >> 1;
      if (op == 3'd7 && $urandom_range(0, 3) == 0) b = 0;
      run_op($sformatf("rand%0d_w%0d_op%0d", i, w, op), w, op, a, b, 0, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound on the run
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
